// File: rtl/matrix_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : matrix_scan_if
// Brief    : Pixel-write, swap and column-word bundle for matrix_scan.
// Revision : 1.0
// ============================================================================
interface matrix_scan_if;
    logic        wr_en;
    logic [2:0]  wr_col;
    logic [3:0]  wr_row;
    logic        wr_pix;
    logic        clr;
    logic        swap_req;
    logic        st_cp_in;
    logic [24:0] out;
    logic [2:0]  col_idx;
    logic        swap_ack;
    logic        frame_tick;

    modport master (
        output wr_en, wr_col, wr_row, wr_pix, clr, swap_req, st_cp_in,
        input  out, col_idx, swap_ack, frame_tick
    );

    modport slave (
        input  wr_en, wr_col, wr_row, wr_pix, clr, swap_req, st_cp_in,
        output out, col_idx, swap_ack, frame_tick
    );
endinterface
`default_nettype wire

// File: rtl/matrix_scan.sv
`default_nettype none
// ============================================================================
// Module   : matrix_scan
// Brief    : Double-buffered 8x16 LED column scanner paced by an external latch
//            strobe. Optional macro SCAN_GHOST_BLANK_EN inserts a blank column
//            word between columns.
// Revision : 1.0
// ============================================================================
module matrix_scan #(
    parameter int DWELL = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    matrix_scan_if.slave    bus
);
    localparam logic [7:0]  C_DWELL_LAST = 8'(DWELL - 1);
    localparam logic [24:0] C_OUT_RESET  = 25'h0FE0000;
    localparam logic [24:0] C_OUT_BLANK  = {1'b0, 8'hFF, 16'h0000};

    typedef enum logic [0:0] {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    state_t          r_state_q, w_state_d;
    logic [2:0]      r_sync_q,  w_sync_d;
    logic [7:0]      r_dwell_q, w_dwell_d;
    logic [2:0]      r_col_q,   w_col_d;
    logic            r_pend_q,  w_pend_d;
    logic [7:0][15:0] r_front_q, w_front_d;
    logic [7:0][15:0] r_back_q,  w_back_d;
    logic [24:0]     r_out_q,   w_out_d;
    logic            r_ack_q,   w_ack_d;
    logic            r_tick_q,  w_tick_d;
    logic            w_latch;
    logic            w_advance;
    logic            w_wrap;

    always_comb begin
        w_state_d = r_state_q;
        w_dwell_d = r_dwell_q;
        w_advance = 1'b0;

        // [1:0] is the two-flop synchronizer, [2] remembers the previous sample
        w_sync_d = {r_sync_q[1:0], bus.st_cp_in};
        w_latch  = r_sync_q[1] & ~r_sync_q[2];

        w_back_d = r_back_q;
        if (bus.clr) begin
            w_back_d = '0;
        end else if (bus.wr_en) begin
            w_back_d[bus.wr_col][bus.wr_row] = bus.wr_pix;
        end

        if (w_latch) begin
            case (r_state_q)
                ST_SHOW: begin
                    if (r_dwell_q == C_DWELL_LAST) begin
                        w_dwell_d = '0;
`ifdef SCAN_GHOST_BLANK_EN
                        w_state_d = ST_BLANK;
`else
                        w_advance = 1'b1;
`endif
                    end else begin
                        w_dwell_d = r_dwell_q + 8'd1;
                    end
                end
                ST_BLANK: begin
                    w_state_d = ST_SHOW;
                    w_advance = 1'b1;
                end
            endcase
        end

        w_col_d  = w_advance ? (r_col_q + 3'd1) : r_col_q;
        w_wrap   = w_advance && (r_col_q == 3'd7);
        w_tick_d = w_wrap;

        // Front copies the back buffer after this cycle's write/clear is applied
        w_ack_d   = 1'b0;
        w_front_d = r_front_q;
        w_pend_d  = r_pend_q | bus.swap_req;
        if (w_wrap && w_pend_d) begin
            w_front_d = w_back_d;
            w_pend_d  = 1'b0;
            w_ack_d   = 1'b1;
        end

        if (r_state_q == ST_BLANK) begin
            w_out_d = C_OUT_BLANK;
        end else begin
            w_out_d = {1'b0, ~(8'h01 << r_col_q), r_front_q[r_col_q]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_SHOW;
            r_sync_q  <= '0;
            r_dwell_q <= '0;
            r_col_q   <= '0;
            r_pend_q  <= 1'b0;
            r_front_q <= '0;
            r_back_q  <= '0;
            r_out_q   <= C_OUT_RESET;
            r_ack_q   <= 1'b0;
            r_tick_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_sync_q  <= w_sync_d;
            r_dwell_q <= w_dwell_d;
            r_col_q   <= w_col_d;
            r_pend_q  <= w_pend_d;
            r_front_q <= w_front_d;
            r_back_q  <= w_back_d;
            r_out_q   <= w_out_d;
            r_ack_q   <= w_ack_d;
            r_tick_q  <= w_tick_d;
        end
    end

    assign bus.out        = r_out_q;
    assign bus.col_idx    = r_col_q;
    assign bus.swap_ack   = r_ack_q;
    assign bus.frame_tick = r_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_matrix_scan
// Brief    : Self-checking bench for matrix_scan with a frame-level reference.
// Revision : 1.0
// ============================================================================
module tb_matrix_scan;
    localparam int DWELL = 4;

    logic clk = 1'b0;
    logic rst;
    matrix_scan_if bus ();

    matrix_scan #(.DWELL(DWELL)) u_dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int tick_cnt = 0;
    int ack_cnt = 0;
    int stray_ack = 0;
    int reset_pulse = 0;

    always @(negedge clk) begin
        if (bus.frame_tick === 1'b1) tick_cnt++;
        if (bus.swap_ack === 1'b1) ack_cnt++;
        if (bus.swap_ack === 1'b1 && bus.frame_tick !== 1'b1) stray_ack++;
        if (rst === 1'b1 && (bus.frame_tick !== 1'b0 || bus.swap_ack !== 1'b0)) reset_pulse++;
    end

    // Reference model: displayed/written images plus scan position
    logic [15:0] m_front [8];
    logic [15:0] m_back  [8];
    int m_col, m_dwell, m_frames, m_acks;
    bit m_pend, m_blank;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_front[i] = '0;
            m_back[i]  = '0;
        end
        m_col = 0; m_dwell = 0; m_pend = 0; m_blank = 0;
    endfunction

    function automatic void model_write(bit wr, bit cl, int c, int r, bit p);
        if (cl) begin
            for (int i = 0; i < 8; i++) m_back[i] = '0;
        end else if (wr) begin
            m_back[c][r] = p;
        end
    endfunction

    function automatic void model_advance();
        m_col = (m_col + 1) % 8;
        if (m_col == 0) begin
            m_frames++;
            if (m_pend) begin
                for (int i = 0; i < 8; i++) m_front[i] = m_back[i];
                m_pend = 0;
                m_acks++;
            end
        end
    endfunction

    function automatic void model_event();
        if (m_blank) begin
            m_blank = 0;
            model_advance();
        end else if (m_dwell == DWELL - 1) begin
            m_dwell = 0;
`ifdef SCAN_GHOST_BLANK_EN
            m_blank = 1;
`else
            model_advance();
`endif
        end else begin
            m_dwell++;
        end
    endfunction

    function automatic logic [24:0] model_out();
        logic [7:0] sel;
        sel = 8'(255 - (1 << m_col));
        if (m_blank) return {1'b0, 8'hFF, 16'h0000};
        return {1'b0, sel, m_front[m_col]};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_state(string tag);
        check({tag, " col_idx"}, 32'(bus.col_idx), 32'(m_col));
        check({tag, " out"}, 32'(bus.out), 32'(model_out()));
        check({tag, " frame_tick count"}, 32'(tick_cnt), 32'(m_frames));
        check({tag, " swap_ack count"}, 32'(ack_cnt), 32'(m_acks));
    endtask

    // One-cycle command; called and returns at a falling edge
    task automatic drive_cmd(bit wr, bit cl, bit sw, int c, int r, bit p);
        bus.wr_en = wr; bus.clr = cl; bus.swap_req = sw;
        bus.wr_col = 3'(c); bus.wr_row = 4'(r); bus.wr_pix = p;
        @(negedge clk);
        bus.wr_en = 1'b0; bus.clr = 1'b0; bus.swap_req = 1'b0;
        model_write(wr, cl, c, r, p);
        if (sw) m_pend = 1;
    endtask

    // Strobe pulse; the optional side command lands in the cycle the event is acted on
    task automatic latch_event(bit side, bit wr, bit cl, bit sw, int c, int r, bit p);
        bus.st_cp_in = 1'b1;
        repeat (2) @(negedge clk);
        bus.st_cp_in = 1'b0;
        if (side) begin
            bus.wr_en = wr; bus.clr = cl; bus.swap_req = sw;
            bus.wr_col = 3'(c); bus.wr_row = 4'(r); bus.wr_pix = p;
        end
        @(negedge clk);
        bus.wr_en = 1'b0; bus.clr = 1'b0; bus.swap_req = 1'b0;
        if (side) begin
            model_write(wr, cl, c, r, p);
            if (sw) m_pend = 1;
        end
        model_event();
        repeat (3) @(negedge clk);
        check_state("event");
    endtask

    task automatic plain_event();
        latch_event(0, 0, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        int          col;
        int          row;
        bit          pix;
        bit          cl;
        logic [15:0] exp_word;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int f0, a0, a_save;
        logic [24:0] o_save;

        vecs[0] = '{3, 5,  1'b1, 1'b0, 16'h0020};
        vecs[1] = '{0, 0,  1'b1, 1'b1, 16'h0000};
        vecs[2] = '{7, 15, 1'b1, 1'b0, 16'h8000};
        vecs[3] = '{7, 0,  1'b1, 1'b0, 16'h8001};
        vecs[4] = '{7, 15, 1'b0, 1'b0, 16'h0001};
        vecs[5] = '{2, 9,  1'b1, 1'b0, 16'h0200};
        vecs[6] = '{0, 3,  1'b1, 1'b0, 16'h0008};
        vecs[7] = '{2, 9,  1'b0, 1'b1, 16'h0000};

        rst = 1'b1;
        bus.wr_en = 0; bus.wr_col = 0; bus.wr_row = 0; bus.wr_pix = 0;
        bus.clr = 0; bus.swap_req = 0; bus.st_cp_in = 0;
        m_frames = 0; m_acks = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset out", 32'(bus.out), 32'h00FE0000);
        check("reset col_idx", 32'(bus.col_idx), 32'd0);
        check("reset frame_tick", 32'(bus.frame_tick), 32'd0);
        check("reset swap_ack", 32'(bus.swap_ack), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // First column advance and its select word
        for (int i = 0; i < DWELL - 1; i++) plain_event();
        check("pre-advance select", 32'(bus.out[23:16]), 32'h000000FE);
        plain_event();
`ifndef SCAN_GHOST_BLANK_EN
        check("post-advance col", 32'(bus.col_idx), 32'd1);
        check("post-advance select", 32'(bus.out[23:16]), 32'h000000FD);
`endif

        // Table: write (optionally with clr), swap, then inspect the written column
        for (int v = 0; v < 8; v++) begin
            a0 = ack_cnt;
            bus.wr_en = 1'b1; bus.clr = vecs[v].cl; bus.swap_req = 1'b1;
            bus.wr_col = 3'(vecs[v].col); bus.wr_row = 4'(vecs[v].row); bus.wr_pix = vecs[v].pix;
            @(negedge clk);
            bus.wr_en = 1'b0; bus.clr = 1'b0; bus.swap_req = 1'b0;
            model_write(1, vecs[v].cl, vecs[v].col, vecs[v].row, vecs[v].pix);
            m_pend = 1;
            f0 = m_frames;
            while (m_frames == f0) plain_event();
            while (m_col != vecs[v].col || m_blank) plain_event();
            check("table col_idx", 32'(bus.col_idx), 32'(vecs[v].col));
            check("table row word", 32'(bus.out[15:0]), 32'(vecs[v].exp_word));
            check("table swap_ack once", 32'(ack_cnt - a0), 32'd1);
        end

        // Write and swap request arriving in the wrap cycle itself
        while (!(m_col == 7 && ((m_dwell == DWELL - 1 && !m_blank) || m_blank)) ) plain_event();
`ifdef SCAN_GHOST_BLANK_EN
        if (!m_blank) plain_event();
`endif
        a0 = ack_cnt;
        latch_event(1, 1, 0, 1, 0, 11, 1);
        check("wrap-cycle swap ack", 32'(ack_cnt - a0), 32'd1);
        check("wrap-cycle write visible", 32'(bus.out[15:0]), 32'(m_front[0]));

        // Strobe held high: a single event, acted on at the third edge
        while (!(m_dwell == DWELL - 1 && !m_blank)) plain_event();
        o_save = bus.out;
        bus.st_cp_in = 1'b1;
        repeat (2) @(negedge clk);
        check("hold no early event", 32'(bus.col_idx), 32'(m_col));
        @(negedge clk);
        model_event();
        check("hold event at 3rd edge", 32'(bus.col_idx), 32'(m_col));
        repeat (8) @(negedge clk);
        bus.st_cp_in = 1'b0;
        repeat (4) @(negedge clk);
        check_state("hold");
        plain_event();

        // Idle: nothing moves without strobes
        o_save = bus.out;
        repeat (50) @(negedge clk);
        check("idle out", 32'(bus.out), 32'(o_save));
        check_state("idle");

        // Reset with a pending swap and a partial dwell count
        drive_cmd(1, 0, 1, 4, 4, 1);
        while (!(m_dwell == 2 && !m_blank)) plain_event();
        rst = 1'b1;
        @(negedge clk);
        bus.st_cp_in = 1'b1;
        repeat (2) @(negedge clk);
        bus.st_cp_in = 1'b0;
        repeat (3) @(negedge clk);
        check("mid reset out", 32'(bus.out), 32'h00FE0000);
        check("mid reset col_idx", 32'(bus.col_idx), 32'd0);
        rst = 1'b0;
        model_reset();
        m_frames = tick_cnt; m_acks = ack_cnt;
        a_save = ack_cnt;
        f0 = m_frames;
        while (m_frames == f0) plain_event();
        check("no swap after reset", 32'(ack_cnt), 32'(a_save));

        // Randomized traffic against the reference model
        for (int i = 0; i < 250; i++) begin
            int n;
            n = int'($urandom_range(0, 2));
            for (int k = 0; k < n; k++)
                drive_cmd(1, $urandom_range(0, 15) == 0, 0,
                          int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)));
            if ($urandom_range(0, 5) == 0) drive_cmd(0, 0, 1, 0, 0, 0);
            if ($urandom_range(0, 7) == 0)
                latch_event(1, 1, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
                            int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                            1'($urandom_range(0, 1)));
            else
                plain_event();
            if ($urandom_range(0, 15) == 0) repeat ($urandom_range(1, 20)) @(negedge clk);
        end

        check("swap_ack without frame_tick", 32'(stray_ack), 32'd0);
        check("pulses during reset", 32'(reset_pulse), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/matrix_scan.md
MATRIX_SCAN -- requirements
Module: matrix_scan

Interface
REQ-001 Parameter: DWELL, default 4, number of latch events each column stays displayed (legal 1-255).
REQ-002 CLK  input  1  single system clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 wr_en  input  1  write one pixel of the back buffer this cycle.
REQ-005 wr_col  input  3  column address of the pixel write (0-7).
REQ-006 wr_row  input  4  row address of the pixel write (0-15).
REQ-007 wr_pix  input  1  pixel value to write; 1 = LED on.
REQ-008 clr  input  1  clear the entire back buffer to 0 in one cycle.
REQ-009 swap_req  input  1  single-cycle pulse requesting a back/front buffer swap.
REQ-010 st_cp_in  input  1  latch strobe from the downstream column shifter; asynchronous to CLK.
REQ-011 out  output  25  column word to the shifter: [15:0] row pixels, [23:16] column select active-low, [24] fixed 0.
REQ-012 col_idx  output  3  index of the column currently driven.
REQ-013 swap_ack  output  1  one-cycle pulse when a pending swap takes effect.
REQ-014 frame_tick  output  1  one-cycle pulse when the scan wraps from column 7 to column 0.

Function
REQ-015 Storage: two 8x16-bit buffers (front = displayed, back = written); the block has no read port.
REQ-016 st_cp_in passes through a 2-flop synchronizer; a latch event is one CLK cycle on the synchronized rising edge, 3 cycles after the input rise.
REQ-017 The dwell counter increments on every latch event; at DWELL-1 the event instead resets it to 0 and advances the column.
REQ-018 Column advance: col_idx increments modulo 8; at the 7->0 wrap, frame_tick pulses in the same cycle col_idx becomes 0.
REQ-019 SHOW state drives out = {1'b0, ~(8'h01 << col_idx), front[col_idx]}, registered, updated 1 cycle after the event that changes col_idx.
REQ-020 Writes: wr_en sets back[wr_col][wr_row] = wr_pix on the next edge; front is never written directly.
REQ-021 clr and wr_en in the same cycle: clr wins and the write is discarded.
REQ-022 A swap_req pulse sets swap_pending; an additional swap_req while pending has no extra effect.
REQ-023 A pending swap executes only at the 7->0 wrap: front takes back, back keeps its contents, swap_pending clears, swap_ack pulses together with frame_tick.
REQ-024 A swap_req in the same cycle as the wrap is honoured at that wrap.
REQ-025 A write or clr in the swap cycle acts on back before the copy, so front receives the updated data.
REQ-026 No latch events means no output change: out and col_idx hold indefinitely.

Reset
REQ-027 While RST is high: both buffers = 0, col_idx = 0, dwell counter = 0, swap_pending = 0, synchronizer flops = 0, state = SHOW.
REQ-028 While RST is high: out = 25'h0FE0000, swap_ack = 0, frame_tick = 0.
REQ-029 RST mid-scan discards any pending swap and any in-progress dwell count; a latch edge present during reset is not counted.

Configuration
REQ-030 Macro SCAN_GHOST_BLANK_EN, when defined, adds state BLANK: the event that would advance the column enters BLANK, with out = {1'b0, 8'hFF, 16'h0}.
REQ-031 With SCAN_GHOST_BLANK_EN defined, the next latch event leaves BLANK: SHOW resumes, the column advances, and frame_tick/swap occur on that event.
REQ-032 Without the macro there is no BLANK state and columns advance directly as in REQ-017.

Verification
REQ-033 Reset, then 4 latch pulses (DWELL=4) -> col_idx goes 0->1 one cycle after the 4th event; out[23:16] goes 8'hFE -> 8'hFD.
REQ-034 Write back[3][5]=1, swap_req, then 32 latch events -> frame_tick and swap_ack together at the wrap; with col_idx=3, out[15:0]=16'h0020.
REQ-035 clr and wr_en (col 0, row 0, pix 1) in the same cycle, then swap -> out[15:0]=16'h0000 while col_idx=0.
REQ-036 RST asserted with swap_pending set and dwell count 2 -> out=25'h0FE0000; the next full frame produces no swap_ack.
REQ-037 With SCAN_GHOST_BLANK_EN, DWELL=1: event1 -> out[23:16]=8'hFF; event2 -> col_idx=1, out[23:16]=8'hFD.
REQ-038 st_cp_in held high for 10 cycles -> exactly one latch event, occurring 3 cycles after the rise.
